// File: rtl/seq_divider8.sv
// rtl/seq_divider8.sv - iterative radix-2 restoring divider (optional DIV_SIGNED_EN for two's complement)
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef DIV_SIGNED_EN
  // One extra CALC cycle applies the sign fix-up before DONE.
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] dvd_q;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dsr_q;     // divisor (magnitude in signed builds)
  logic [WIDTH-1:0] num_q;     // original dividend, returned as remainder on divide by zero
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, dvd_nx;

`ifdef DIV_SIGNED_EN
  logic q_neg_q, r_neg_q;

  // Strip signs on entry; the most negative value maps to its unsigned magnitude.
  always_comb begin
    mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
  end
`else
  // Unsigned operands are divided as-is.
  always_comb begin
    mag_a = dividend;
    mag_b = divisor;
  end
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsr_q});
    // When the trial fits the true difference is below the divisor, so the low bits are exact.
    rem_nx  = fits ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
    dvd_nx  = {dvd_q[WIDTH-2:0], fits};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; start is only honoured outside CALC.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = CALC;
      CALC: begin
        if (dsr_q == '0)            state_n = DONE;
        else if (cnt_q == LAST_ITER) state_n = DONE;
      end
      DONE: state_n = start ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers written only on the done edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else if (state != CALC) begin
      if (start) begin
        rem_q   <= '0;
        dvd_q   <= mag_a;
        dsr_q   <= mag_b;
        num_q   <= dividend;
        cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
        q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_q <= dividend[WIDTH-1];
`endif
      end
    end else begin
      if (dsr_q == '0) begin
        quotient    <= '1;
        remainder   <= num_q;
        div_by_zero <= 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
        if (cnt_q == LAST_ITER) begin
          quotient    <= q_neg_q ? -dvd_q : dvd_q;
          remainder   <= r_neg_q ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
        end else begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          cnt_q <= cnt_q + CW'(1);
        end
`else
        rem_q <= rem_nx;
        dvd_q <= dvd_nx;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          quotient    <= dvd_nx;
          remainder   <= rem_nx;
          div_by_zero <= 1'b0;
        end
`endif
      end
    end
  end

  // Status outputs decode directly from the state.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_divider8.sv
// tb/tb_seq_divider8.sv - randomized self-checking bench for seq_divider8 against an arithmetic model
module tb_seq_divider8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  seq_divider8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain language arithmetic on the operands.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z,
                       output int lat);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1; lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sb, sq, sr;
      sa = int'($signed(a)); sb = int'($signed(b));
      sq = sa / sb; sr = sa % sb;
      q = sq[7:0]; r = sr[7:0];
`else
      q = a / b; r = a % b;
`endif
      z = 1'b0; lat = LAT;
    end
  endtask

  // Present one start pulse; it is accepted at the next rising edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("done_after_accept", done, 1'b0);
  endtask

  // Count edges from the accepting edge until done; pre = edges already consumed.
  task automatic wait_done(input string tag, input int pre, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er; logic ez; int lat; int n; logic busy_ok;
    model(a, b, eq, er, ez, lat);
    n = pre; busy_ok = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (n > 40) break;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_during"}, busy_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
  endtask

  // Verify the pulse drops and results hold one cycle after done.
  task automatic after_done(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er; logic ez; int lat;
    model(a, b, eq, er, ez, lat);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_q_hold"}, quotient, eq);
    check({tag, "_r_hold"}, remainder, er);
    check({tag, "_dbz_hold"}, div_by_zero, ez);
  endtask

  initial begin
    logic [7:0] a, b;
    int seen;

    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 8'h00);
    check("rst_r", remainder, 8'h00);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk); rst = 1'b0;

`ifdef DIV_SIGNED_EN
    launch(8'h9C, 8'd7);  wait_done("neg100_7", 0, 8'h9C, 8'd7);  after_done("neg100_7", 8'h9C, 8'd7);
    launch(8'h80, 8'hFF); wait_done("neg128_m1", 0, 8'h80, 8'hFF); after_done("neg128_m1", 8'h80, 8'hFF);
`endif

    launch(8'd200, 8'd7); wait_done("d200_7", 0, 8'd200, 8'd7); after_done("d200_7", 8'd200, 8'd7);
    launch(8'd13, 8'd0);  wait_done("d13_0", 0, 8'd13, 8'd0);   after_done("d13_0", 8'd13, 8'd0);

    // Back-to-back: second start presented during the done cycle.
    launch(8'd255, 8'd1); wait_done("d255_1", 0, 8'd255, 8'd1);
    launch(8'd100, 8'd10);
    check("b2b_q_held", quotient, 8'd255);
    check("b2b_r_held", remainder, 8'd0);
    wait_done("d100_10", 0, 8'd100, 8'd10); after_done("d100_10", 8'd100, 8'd10);

    // Start during CALC must be ignored.
    launch(8'd50, 8'd6);
    @(negedge clk); start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk); start = 1'b0;
    wait_done("d50_6_ign", 1, 8'd50, 8'd6); after_done("d50_6_ign", 8'd50, 8'd6);

    // Asynchronous reset mid-division.
    launch(8'd77, 8'd5);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, 8'h00);
    check("midrst_r", remainder, 8'h00);
    check("midrst_dbz", div_by_zero, 1'b0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    launch(8'd77, 8'd5); wait_done("d77_5", 0, 8'd77, 8'd5); after_done("d77_5", 8'd77, 8'd5);

    // Random operands, with a share of zero divisors and boundary values.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 5))
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      if (i % 10 == 3) a = 8'h80;
      launch(a, b);
      wait_done("rand", 0, a, b);
      if (i % 4 == 0) after_done("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
